// File: rtl/self_control_pkg.sv
// Shared constants for the player-sprite control path: datapath ops, FSM states
// and the clamped X-movement helper.
package self_pkg;

  localparam logic [1:0] OP_DRAW  = 2'd0;
  localparam logic [1:0] OP_ERASE = 2'd1;
  localparam logic [1:0] OP_FIRE  = 2'd2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ERASE  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_DRAW   = 2'd3;

  localparam int SPRITE_PIXELS = 25;

  // Signed int arithmetic so a step below X_MIN clamps instead of wrapping.
  function automatic logic [7:0] move_x(input logic [7:0] x, input logic left,
                                        input logic right, input int step,
                                        input int x_min, input int x_max);
    int xi;
    xi = int'(x);
    if (left && !right)
      xi = (xi - step < x_min) ? x_min : xi - step;
    else if (right && !left)
      xi = (xi + step > x_max) ? x_max : xi + step;
    return 8'(xi);
  endfunction

endpackage

// File: rtl/self_control_frame_tick_gen.sv
// Frame divider: free-running 0..FRAME_DIV-1 counter with a one-cycle tick on
// the terminal count.
module frame_tick_gen #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(FRAME_DIV);
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] div_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      div_cnt_reg <= '0;
    else if (div_cnt_reg == LAST)
      div_cnt_reg <= '0;
    else
      div_cnt_reg <= div_cnt_reg + 1'b1;
  end

  assign tick = (div_cnt_reg == LAST);

endmodule

// File: rtl/self_control.sv
// Player-sprite control FSM: once per frame erases the sprite, moves it with
// edge clamping, reloads X into the datapath and redraws it (fire graphic optional).
module self_control
  import self_pkg::*;
#(
  parameter int FRAME_DIV   = 833333,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 155,
  parameter int X_INIT      = 82,
  parameter int STEP        = 1,
  parameter int FIRE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       fire_btn,
  output logic [7:0] x_pos,
  output logic [1:0] op_out,
  output logic       load,
  output logic       enable,
  output logic       plot,
  output logic       busy
);

  localparam int FW = $clog2(FIRE_FRAMES + 1);
  localparam logic [4:0] PIX_LAST = 5'(SPRITE_PIXELS - 1);

  logic          tick;
  logic [1:0]    state_reg;
  logic [4:0]    pix_cnt_reg;
  logic [FW-1:0] fire_cnt_reg;
  logic          tick_pend_reg;
  logic          left_reg;
  logic          right_reg;
  logic          fire_prev_reg;
  logic [7:0]    x_reg;
  logic [1:0]    op_reg;
  logic          load_reg;
  logic          enable_reg;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Outputs are registered alongside the state transition, so enable is
  // already high in the first erase cycle right after the tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      pix_cnt_reg   <= '0;
      fire_cnt_reg  <= '0;
      tick_pend_reg <= 1'b0;
      left_reg      <= 1'b0;
      right_reg     <= 1'b0;
      fire_prev_reg <= 1'b0;
      x_reg         <= 8'(X_INIT);
      op_reg        <= OP_DRAW;
      load_reg      <= 1'b0;
      enable_reg    <= 1'b0;
    end else begin
      load_reg <= 1'b0;
      if (tick && (state_reg != S_IDLE))
        tick_pend_reg <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (tick || tick_pend_reg) begin
            tick_pend_reg <= 1'b0;
            left_reg      <= move_left;
            right_reg     <= move_right;
            fire_prev_reg <= fire_btn;
            if (fire_btn && !fire_prev_reg)
              fire_cnt_reg <= FW'(FIRE_FRAMES);
            state_reg   <= S_ERASE;
            pix_cnt_reg <= '0;
            op_reg      <= OP_ERASE;
            enable_reg  <= 1'b1;
          end
        end
        S_ERASE: begin
          if (pix_cnt_reg == PIX_LAST) begin
            state_reg   <= S_UPDATE;
            pix_cnt_reg <= '0;
            enable_reg  <= 1'b0;
            load_reg    <= 1'b1;
            x_reg       <= move_x(x_reg, left_reg, right_reg, STEP, X_MIN, X_MAX);
          end else begin
            pix_cnt_reg <= pix_cnt_reg + 1'b1;
          end
        end
        S_UPDATE: begin
          state_reg  <= S_DRAW;
          enable_reg <= 1'b1;
          op_reg     <= (fire_cnt_reg != '0) ? OP_FIRE : OP_DRAW;
        end
        S_DRAW: begin
          if (pix_cnt_reg == PIX_LAST) begin
            state_reg   <= S_IDLE;
            pix_cnt_reg <= '0;
            enable_reg  <= 1'b0;
            op_reg      <= OP_DRAW;
            if (fire_cnt_reg != '0)
              fire_cnt_reg <= fire_cnt_reg - 1'b1;
          end else begin
            pix_cnt_reg <= pix_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg  <= S_IDLE;
          enable_reg <= 1'b0;
        end
      endcase
    end
  end

  assign x_pos  = x_reg;
  assign op_out = op_reg;
  assign load   = load_reg;
  assign enable = enable_reg;
  assign plot   = enable_reg;
  assign busy   = (state_reg != S_IDLE);

endmodule

// File: tb/tb_self_control.sv
// Scoreboard bench for self_control: one expected record per frame pass,
// checked against what the monitor observes on the datapath/VGA outputs.
module tb_self_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       move_left, move_right, fire_btn;
  logic [7:0] x_pos;
  logic [1:0] op_out;
  logic       load, enable, plot, busy;

  typedef struct {
    int x_load;
    int draw_op;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  // reference state
  int mx, mfc, mfp;

  // monitor state
  int in_pass, busy_n, erase_n, draw_n, load_n, x_load_o, draw_op_o;
  int order_bad, plot_bad, idle_n, gap_obs, idle_bad;

  always #5 clk = ~clk;

  self_control #(.FRAME_DIV(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .move_left  (move_left),
    .move_right (move_right),
    .fire_btn   (fire_btn),
    .x_pos      (x_pos),
    .op_out     (op_out),
    .load       (load),
    .enable     (enable),
    .plot       (plot),
    .busy       (busy)
  );

  task automatic check(input string tag, input int got, input int want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic finish_pass();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_pop", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      $display("[TB] pass x_load=%0d draw_op=%0d erase=%0d draw=%0d busy=%0d",
               x_load_o, draw_op_o, erase_n, draw_n, busy_n);
      check("erase_cnt", erase_n, 25);
      check("load_cnt", load_n, 1);
      check("x_load", x_load_o, e.x_load);
      check("draw_cnt", draw_n, 25);
      check("draw_op", draw_op_o, e.draw_op);
      check("busy_len", busy_n, 51);
      check("order", order_bad, 0);
      check("plot_eq", plot_bad, 0);
      check("x_hold", int'(x_pos), e.x_load);
      if (e.gap >= 0) check("gap", gap_obs, e.gap);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      in_pass = 0;
      idle_n  = 0;
    end else if (busy) begin
      if (in_pass == 0) begin
        in_pass = 1; gap_obs = idle_n; idle_n = 0;
        busy_n = 0; erase_n = 0; draw_n = 0; load_n = 0;
        x_load_o = -1; draw_op_o = -1; order_bad = 0; plot_bad = 0;
      end
      busy_n++;
      if (plot !== enable) plot_bad++;
      if (enable && op_out == 2'd1) begin
        erase_n++;
        if (draw_n != 0 || load_n != 0) order_bad++;
      end else if (enable) begin
        if (draw_n == 0) draw_op_o = int'(op_out);
        else if (int'(op_out) != draw_op_o) order_bad++;
        if (load_n == 0) order_bad++;
        draw_n++;
      end
      if (load) begin
        load_n++;
        x_load_o = int'(x_pos);
        if (enable) order_bad++;
      end
    end else begin
      if (in_pass != 0) begin
        in_pass = 0;
        finish_pass();
      end
      if (enable || load || plot) idle_bad++;
      idle_n++;
    end
  end

  task automatic wait_busy(input logic v, input int limit, input string tag);
    int n = 0;
    while (busy !== v && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy !== v) check(tag, int'(busy), int'(v));
  endtask

  task automatic model_push(input logic l, input logic r, input logic f, input int gap);
    exp_t e;
    if (f && mfp == 0) mfc = 8;
    mfp = int'(f);
    if (l && !r) mx = (mx - 1 < 0) ? 0 : mx - 1;
    else if (r && !l) mx = (mx + 1 > 155) ? 155 : mx + 1;
    e.x_load  = mx;
    e.draw_op = (mfc != 0) ? 2 : 0;
    if (mfc != 0) mfc--;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic do_pass(input logic l, input logic r, input logic f);
    @(negedge clk);
    move_left = l; move_right = r; fire_btn = f;
    model_push(l, r, f, -1);
    wait_busy(1'b1, 400, "start_timeout");
    wait_busy(1'b0, 100, "end_timeout");
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; move_left = 1'b0; move_right = 1'b0; fire_btn = 1'b0;
    mx = 82; mfc = 0; mfp = 0; idle_bad = 0; in_pass = 0; idle_n = 0;
    repeat (3) @(negedge clk);
    check("rst_x", int'(x_pos), 82);
    check("rst_op", int'(op_out), 0);
    check("rst_load", int'(load), 0);
    check("rst_en", int'(enable), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;

    do_pass(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_pass(1'b0, 1'b1, 1'b0);
    check("x_after_right3", int'(x_pos), 85);
    for (int i = 0; i < 2; i++) do_pass(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 72; i++) do_pass(1'b0, 1'b1, 1'b0);
    check("x_clamp_max", int'(x_pos), 155);

    // fire: press and hold, release, re-press, re-press mid-run
    for (int i = 0; i < 10; i++) do_pass(1'b0, 1'b0, 1'b1);
    do_pass(1'b0, 1'b0, 1'b0);
    do_pass(1'b0, 1'b0, 1'b1);
    do_pass(1'b0, 1'b0, 1'b1);
    do_pass(1'b0, 1'b0, 1'b0);
    do_pass(1'b0, 1'b0, 1'b1);
    do_pass(1'b0, 1'b0, 1'b0);

    // reset in the middle of erase
    @(negedge clk);
    move_left = 1'b0; move_right = 1'b0; fire_btn = 1'b0;
    wait_busy(1'b1, 400, "rst_start_timeout");
    repeat (12) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_en", int'(enable), 0);
    check("midrst_plot", int'(plot), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_x", int'(x_pos), 82);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mx = 82; mfc = 0; mfp = 0;
    do_pass(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 84; i++) do_pass(1'b1, 1'b0, 1'b0);
    check("x_clamp_min", int'(x_pos), 0);

    // divider override: one tick starts a pass, one is pended, one is dropped
    force dut.tick = 1'b0;
    @(negedge clk);
    model_push(1'b0, 1'b0, 1'b0, -1);
    model_push(1'b0, 1'b0, 1'b0, 1);
    force dut.tick = 1'b1;
    @(posedge clk);
    #1;
    force dut.tick = 1'b0;
    check("tick_lat_en", int'(enable), 1);
    check("tick_lat_op", int'(op_out), 1);
    repeat (10) @(negedge clk);
    force dut.tick = 1'b1;
    @(negedge clk);
    force dut.tick = 1'b0;
    repeat (10) @(negedge clk);
    force dut.tick = 1'b1;
    @(negedge clk);
    force dut.tick = 1'b0;
    wait_busy(1'b0, 100, "a_end_timeout");
    @(negedge clk);
    wait_busy(1'b1, 10, "b_start_timeout");
    wait_busy(1'b0, 100, "b_end_timeout");
    repeat (20) @(negedge clk);
    check("tick_drop", int'(busy), 0);
    check("sb_empty", exp_q.size(), 0);
    check("idle_quiet", idle_bad, 0);
    release dut.tick;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
